// File: rtl/ex_muldiv_unit_pkg.sv
// Shared pipeline definitions for the execute-stage multiply/divide unit:
// opcodes, FSM state encoding and the default datapath width.
package pipeline_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [5:0] OP_MUL  = 6'h18;
  localparam logic [5:0] OP_MULU = 6'h19;
  localparam logic [5:0] OP_DIV  = 6'h1A;
  localparam logic [5:0] OP_DIVU = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } muldiv_state_e;

  function automatic logic isMulDiv(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-to-EX/MEM handshake bundle for the multiply/divide unit. The master is
// the pipeline side that issues operations; the slave is the unit itself.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = pipeline_pkg::DEF_WIDTH
);

  logic             valid_in;
  logic [5:0]       alu_op_in;
  logic [WIDTH-1:0] regA_in;
  logic [WIDTH-1:0] regB_in;
  logic [3:0]       regC_adress_in;
  logic             write_inst_in;
  logic             flush;

  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             div_zero;
  logic [3:0]       regC_adress_out;
  logic             write_inst_out;

  modport master (
    output valid_in, alu_op_in, regA_in, regB_in, regC_adress_in, write_inst_in, flush,
    input  stall, busy, done, hi_out, lo_out, div_zero, regC_adress_out, write_inst_out
  );

  modport slave (
    input  valid_in, alu_op_in, regA_in, regB_in, regC_adress_in, write_inst_in, flush,
    output stall, busy, done, hi_out, lo_out, div_zero, regC_adress_out, write_inst_out
  );

endinterface

// File: rtl/ex_muldiv_unit_datapath.sv
// Iterative multiply/divide datapath: a 2*WIDTH accumulator that holds
// {partial product, multiplier} or {remainder, quotient}, plus the sign fix-up.
module muldiv_datapath #(
  parameter int WIDTH = pipeline_pkg::DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               fix_i,
  input  logic               isDiv_i,
  input  logic               isSigned_i,
  input  logic [WIDTH-1:0]   opA_i,
  input  logic [WIDTH-1:0]   opB_i,
  output logic [2*WIDTH-1:0] result_o
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   operand_q;
  logic               isDiv_q;
  logic               negLo_q;
  logic               negHi_q;

  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divTrial;
  logic [WIDTH:0]     divDiff;
  logic               divOk;
  logic [2*WIDTH-1:0] divNext;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;

  assign magA = (isSigned_i && opA_i[WIDTH-1]) ? -opA_i : opA_i;
  assign magB = (isSigned_i && opB_i[WIDTH-1]) ? -opB_i : opB_i;

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right with carry.
  assign mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
  assign mulNext = {mulSum, acc_q[WIDTH-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and keep
  // the difference only when it did not go negative.
  assign divTrial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divDiff  = divTrial - {1'b0, operand_q};
  assign divOk    = ~divDiff[WIDTH];
  assign divNext  = {(divOk ? divDiff[WIDTH-1:0] : divTrial[WIDTH-1:0]), acc_q[WIDTH-2:0], divOk};

  always_comb begin
    fixHi = acc_q[2*WIDTH-1:WIDTH];
    fixLo = acc_q[WIDTH-1:0];
    if (isDiv_q) begin
      if (negHi_q) fixHi = -acc_q[2*WIDTH-1:WIDTH];
      if (negLo_q) fixLo = -acc_q[WIDTH-1:0];
    end else if (negLo_q) begin
      {fixHi, fixLo} = -acc_q;
    end
  end

  assign result_o = {fixHi, fixLo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      operand_q <= '0;
      isDiv_q   <= 1'b0;
      negLo_q   <= 1'b0;
      negHi_q   <= 1'b0;
    end else if (load_i) begin
      isDiv_q <= isDiv_i;
      negLo_q <= isSigned_i && (opA_i[WIDTH-1] ^ opB_i[WIDTH-1]);
      negHi_q <= isSigned_i && isDiv_i && opA_i[WIDTH-1];
      if (isDiv_i) begin
        acc_q     <= {{WIDTH{1'b0}}, magA};
        operand_q <= magB;
      end else begin
        acc_q     <= {{WIDTH{1'b0}}, magB};
        operand_q <= magA;
      end
    end else if (step_i) begin
      acc_q <= isDiv_q ? divNext : mulNext;
    end else if (fix_i) begin
      acc_q <= result_o;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage multi-cycle multiply/divide unit: stalls the front of the pipe
// while iterating and hands a registered hi/lo result plus tag to EX/MEM.
module ex_muldiv_unit
  import pipeline_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_muldiv_unit_if.slave  bus
);

  muldiv_state_e      state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         tag_q;
  logic               wr_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;
  logic               divZero_q;
  logic [3:0]         tagOut_q;
  logic               wrOut_q;

  logic               startCond;
  logic               opIsDiv;
  logic               opIsSigned;
  logic               startZero;
  logic               dpLoad;
  logic               dpStep;
  logic               dpFix;
  logic [2*WIDTH-1:0] dpResult;

  assign opIsDiv    = (bus.alu_op_in == OP_DIV) || (bus.alu_op_in == OP_DIVU);
  assign opIsSigned = (bus.alu_op_in == OP_MUL) || (bus.alu_op_in == OP_DIV);
  assign startCond  = (state_q == IDLE) && bus.valid_in && isMulDiv(bus.alu_op_in) && !bus.flush;
  assign startZero  = startCond && opIsDiv && (bus.regB_in == '0);

  assign dpLoad = startCond && !startZero;
  assign dpStep = (state_q == BUSY) && !bus.flush;
  assign dpFix  = (state_q == FIX) && !bus.flush;

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (dpLoad),
    .step_i    (dpStep),
    .fix_i     (dpFix),
    .isDiv_i   (opIsDiv),
    .isSigned_i(opIsSigned),
    .opA_i     (bus.regA_in),
    .opB_i     (bus.regB_in),
    .result_o  (dpResult)
  );

  // Divide-by-zero skips the iteration entirely and retires straight from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tag_q     <= '0;
      wr_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
      tagOut_q  <= '0;
      wrOut_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush && (state_q != IDLE)) begin
        state_q <= IDLE;
        wrOut_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (startCond) begin
              tag_q     <= bus.regC_adress_in;
              wr_q      <= bus.write_inst_in;
              cnt_q     <= '0;
              divZero_q <= 1'b0;
              if (startZero) begin
                state_q   <= DONE;
                done_q    <= 1'b1;
                divZero_q <= 1'b1;
                hi_q      <= bus.regA_in;
                lo_q      <= '1;
                tagOut_q  <= bus.regC_adress_in;
                wrOut_q   <= bus.write_inst_in;
              end else begin
                state_q <= BUSY;
              end
            end
          end
          BUSY: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
          end
          FIX: begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            hi_q     <= dpResult[2*WIDTH-1:WIDTH];
            lo_q     <= dpResult[WIDTH-1:0];
            tagOut_q <= tag_q;
            wrOut_q  <= wr_q;
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.stall           = startCond || (state_q == BUSY) || (state_q == FIX);
  assign bus.busy            = (state_q != IDLE);
  assign bus.done            = done_q;
  assign bus.hi_out          = hi_q;
  assign bus.lo_out          = lo_q;
  assign bus.div_zero        = divZero_q;
  assign bus.regC_adress_out = tagOut_q;
  assign bus.write_inst_out  = wrOut_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: latency, stall window,
// signed/unsigned results, divide-by-zero, flush and asynchronous reset.
module tb_ex_muldiv_unit;
  import pipeline_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic        stall0;
  int          doneCyc;
  int          stallHigh;
  logic        stallAtDone;
  int          donePulses;
  logic [31:0] prevHi;
  logic [31:0] prevLo;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();

  ex_muldiv_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives a start in the current cycle (called #1 after a rising edge),
  // records stall in that cycle, then scrambles the inputs in cycle 1.
  task automatic startOp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic wr);
    bus.valid_in       = 1'b1;
    bus.alu_op_in      = op;
    bus.regA_in        = a;
    bus.regB_in        = b;
    bus.regC_adress_in = tag;
    bus.write_inst_in  = wr;
    @(negedge clk);
    stall0 = bus.stall;
    @(posedge clk);
    #1;
    bus.valid_in       = 1'b0;
    bus.regA_in        = 32'hDEADBEEF;
    bus.regB_in        = 32'h0BADF00D;
    bus.regC_adress_in = 4'hF;
    bus.write_inst_in  = 1'b0;
  endtask

  // Walks cycles 1..60 until done is seen; returns the done cycle (or -1),
  // how many cycles before it had stall high, and stall in the done cycle.
  task automatic waitDone();
    logic seen;
    seen        = 1'b0;
    doneCyc     = -1;
    stallHigh   = 0;
    stallAtDone = 1'b1;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen        = 1'b1;
        doneCyc     = c;
        stallAtDone = bus.stall;
      end else begin
        if (bus.stall === 1'b1) stallHigh++;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.alu_op_in = '0; bus.regA_in = '0; bus.regB_in = '0;
    bus.regC_adress_in = '0; bus.write_inst_in = 1'b0; bus.flush = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if ({bus.hi_out, bus.lo_out} !== 64'h0) begin
      fails++; $display("[TB] FAIL reset_hilo: got %h expected 0", {bus.hi_out, bus.lo_out});
    end
    tests++;
    if ({bus.done, bus.div_zero, bus.busy, bus.stall} !== 4'b0000) begin
      fails++; $display("[TB] FAIL reset_flags: got %b expected 0000", {bus.done, bus.div_zero, bus.busy, bus.stall});
    end
    tests++;
    if ({bus.regC_adress_out, bus.write_inst_out} !== 5'h00) begin
      fails++; $display("[TB] FAIL reset_tag: got %h expected 00", {bus.regC_adress_out, bus.write_inst_out});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mulu();
    startOp(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h3, 1'b1);
    waitDone();
    tests++;
    if (stall0 !== 1'b1) begin
      fails++; $display("[TB] FAIL mulu_stall_c0: got %b expected 1", stall0);
    end
    tests++;
    if (doneCyc != 34) begin
      fails++; $display("[TB] FAIL mulu_latency: got %0d expected 34", doneCyc);
    end
    tests++;
    if (stallHigh != 33 || stallAtDone !== 1'b0) begin
      fails++; $display("[TB] FAIL mulu_stall_window: got %0d/%b expected 33/0", stallHigh, stallAtDone);
    end
    tests++;
    if (bus.hi_out !== 32'hFFFFFFFE || bus.lo_out !== 32'h00000001) begin
      fails++; $display("[TB] FAIL mulu_result: got %h_%h expected fffffffe_00000001", bus.hi_out, bus.lo_out);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("[TB] FAIL mulu_done_pulse: got done=%b busy=%b expected 0/0", bus.done, bus.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mul_signed();
    startOp(OP_MUL, 32'hFFFFFFF9, 32'd6, 4'hA, 1'b1);
    waitDone();
    tests++;
    if (bus.hi_out !== 32'hFFFFFFFF || bus.lo_out !== 32'hFFFFFFD6) begin
      fails++; $display("[TB] FAIL mul_result: got %h_%h expected ffffffff_ffffffd6", bus.hi_out, bus.lo_out);
    end
    tests++;
    if (bus.regC_adress_out !== 4'hA || bus.write_inst_out !== 1'b1) begin
      fails++; $display("[TB] FAIL mul_tag: got %h/%b expected a/1", bus.regC_adress_out, bus.write_inst_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_zero();
    startOp(OP_DIVU, 32'h00001234, 32'h0, 4'h7, 1'b1);
    waitDone();
    tests++;
    if (stall0 !== 1'b1 || doneCyc != 1 || stallAtDone !== 1'b0) begin
      fails++; $display("[TB] FAIL divzero_timing: got stall0=%b done@%0d stall=%b expected 1/1/0", stall0, doneCyc, stallAtDone);
    end
    tests++;
    if (bus.div_zero !== 1'b1) begin
      fails++; $display("[TB] FAIL divzero_flag: got %b expected 1", bus.div_zero);
    end
    tests++;
    if (bus.hi_out !== 32'h00001234 || bus.lo_out !== 32'hFFFFFFFF) begin
      fails++; $display("[TB] FAIL divzero_result: got %h_%h expected 00001234_ffffffff", bus.hi_out, bus.lo_out);
    end
    @(posedge clk);
    #1;
  endtask

  // Each divide starts in the IDLE cycle directly following the previous DONE.
  task automatic test_back_to_back_div();
    startOp(OP_DIV, 32'hFFFFFFEF, 32'd5, 4'h2, 1'b1);
    waitDone();
    tests++;
    if (bus.lo_out !== 32'hFFFFFFFD || bus.hi_out !== 32'hFFFFFFFE || bus.div_zero !== 1'b0) begin
      fails++; $display("[TB] FAIL div_signed: got %h_%h dz=%b expected fffffffe_fffffffd dz=0", bus.hi_out, bus.lo_out, bus.div_zero);
    end
    @(posedge clk);
    #1;
    startOp(OP_DIVU, 32'd100, 32'd7, 4'h4, 1'b1);
    waitDone();
    tests++;
    if (stall0 !== 1'b1 || doneCyc != 34) begin
      fails++; $display("[TB] FAIL divu_b2b_latency: got stall0=%b done@%0d expected 1/34", stall0, doneCyc);
    end
    tests++;
    if (bus.lo_out !== 32'd14 || bus.hi_out !== 32'd2 || bus.div_zero !== 1'b0) begin
      fails++; $display("[TB] FAIL divu_result: got %h_%h dz=%b expected 00000002_0000000e dz=0", bus.hi_out, bus.lo_out, bus.div_zero);
    end
    @(posedge clk);
    #1;
    startOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 4'h6, 1'b1);
    waitDone();
    tests++;
    if (bus.lo_out !== 32'h80000000 || bus.hi_out !== 32'h0) begin
      fails++; $display("[TB] FAIL div_overflow: got %h_%h expected 00000000_80000000", bus.hi_out, bus.lo_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_flush();
    prevHi = bus.hi_out;
    prevLo = bus.lo_out;
    startOp(OP_MUL, 32'd5, 32'd5, 4'h9, 1'b1);
    for (int c = 1; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.write_inst_out !== 1'b0) begin
      fails++; $display("[TB] FAIL flush_abort: got busy=%b wr=%b expected 0/0", bus.busy, bus.write_inst_out);
    end
    tests++;
    if (bus.hi_out !== prevHi || bus.lo_out !== prevLo) begin
      fails++; $display("[TB] FAIL flush_hold: got %h_%h expected %h_%h", bus.hi_out, bus.lo_out, prevHi, prevLo);
    end
    donePulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) donePulses++;
    end
    tests++;
    if (donePulses != 0) begin
      fails++; $display("[TB] FAIL flush_no_done: got %0d pulses expected 0", donePulses);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b1; bus.alu_op_in = OP_MULU; bus.regA_in = 32'd3; bus.regB_in = 32'd4;
    bus.flush = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.stall !== 1'b0) begin
      fails++; $display("[TB] FAIL flush_idle_stall: got %b expected 0", bus.stall);
    end
    @(posedge clk);
    #1;
    bus.flush = 1'b0; bus.valid_in = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0) begin
      fails++; $display("[TB] FAIL flush_idle_block: got busy=%b expected 0", bus.busy);
    end
    @(posedge clk);
    #1;
    startOp(OP_MULU, 32'd3, 32'd4, 4'h1, 1'b1);
    waitDone();
    tests++;
    if (bus.lo_out !== 32'd12 || bus.hi_out !== 32'd0 || bus.write_inst_out !== 1'b1) begin
      fails++; $display("[TB] FAIL flush_recover: got %h_%h wr=%b expected 00000000_0000000c wr=1", bus.hi_out, bus.lo_out, bus.write_inst_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop();
    startOp(OP_DIV, 32'd1000, 32'd3, 4'hC, 1'b1);
    for (int c = 1; c < 20; c++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.hi_out, bus.lo_out} !== 64'h0 || {bus.done, bus.busy, bus.stall, bus.div_zero} !== 4'b0000) begin
      fails++; $display("[TB] FAIL midop_reset_outputs: got %h_%h flags=%b expected 0_0 flags=0000", bus.hi_out, bus.lo_out, {bus.done, bus.busy, bus.stall, bus.div_zero});
    end
    tests++;
    if ({bus.regC_adress_out, bus.write_inst_out} !== 5'h00) begin
      fails++; $display("[TB] FAIL midop_reset_tag: got %h expected 00", {bus.regC_adress_out, bus.write_inst_out});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.valid_in = 1'b1; bus.alu_op_in = 6'h05; bus.regA_in = 32'd9; bus.regB_in = 32'd1;
    @(negedge clk);
    tests++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("[TB] FAIL nonmuldiv_idle: got stall=%b busy=%b expected 0/0", bus.stall, bus.busy);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++; $display("[TB] FAIL nonmuldiv_no_start: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    bus.valid_in = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_mulu();
    test_mul_signed();
    test_div_zero();
    test_back_to_back_div();
    test_flush();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
